// File: rtl/reset_seq_pkg.sv
// Shared definitions for the staged reset sequencer: FSM state width and encodings.
package reset_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_ASSERT    = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4,
        ST_SWRST     = 3'd5
    } seq_state_e;

endpackage

// File: rtl/reset_sync.sv
// Multi-flop synchroniser with asynchronous clear. Used both for reset-release
// synchronisation (D tied high) and for bringing pll_lock into the clk domain.
module reset_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic i_clr_n,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_chain;

    // Shift chain; cleared immediately when i_clr_n falls, refilled one flop per edge.
    always_ff @(posedge clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset sequencer: synchronises reset release, waits for a stable PLL
// lock, then releases the domain resets one by one in ascending order.
// A software request in RUN re-runs the sequence from the lock hold phase.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4,
    parameter int NUM_DOMAINS = 3,
    parameter int CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   resetb,
    input  logic                   pll_lock,
    input  logic                   sw_reset_req,
    output logic                   sw_reset_ack,
    output logic [NUM_DOMAINS-1:0] domain_resetb,
    output logic                   seq_done,
    output logic [STATE_W-1:0]     seq_state
);

    localparam logic [CNT_W-1:0]       HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]       GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [NUM_DOMAINS-1:0] DOM_ONE   = NUM_DOMAINS'(32'd1);

    logic                   w_rst_n_s;
    logic                   w_lock_s;

    seq_state_e             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [NUM_DOMAINS-1:0] r_dom;
    logic                   r_done;
    logic                   r_ack;

    seq_state_e             w_state_nx;
    logic [CNT_W-1:0]       w_cnt_nx;
    logic [NUM_DOMAINS-1:0] w_dom_nx;
    logic                   w_done_nx;
    logic                   w_ack_nx;
    logic [NUM_DOMAINS-1:0] w_dom_shift;

    // Reset release is only seen by the FSM after SYNC_STAGES clean edges.
    reset_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rst_sync (
        .clk     (clk),
        .i_clr_n (resetb),
        .i_d     (1'b1),
        .o_q     (w_rst_n_s)
    );

    // pll_lock is asynchronous to clk; resync before any decision uses it.
    reset_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
        .clk     (clk),
        .i_clr_n (resetb),
        .i_d     (pll_lock),
        .o_q     (w_lock_s)
    );

    // Next released-domain pattern: one more bit set from the LSB upward.
    assign w_dom_shift = (r_dom << 1'b1) | DOM_ONE;

    // Next-state and next-output logic; lock loss always takes priority.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_dom_nx   = r_dom;
        w_done_nx  = r_done;
        w_ack_nx   = 1'b0;
        case (r_state)
            ST_ASSERT: begin
                w_cnt_nx  = '0;
                w_dom_nx  = '0;
                w_done_nx = 1'b0;
                if (w_rst_n_s) begin
                    w_state_nx = ST_WAIT_LOCK;
                end else begin
                    w_state_nx = ST_ASSERT;
                end
            end
            ST_WAIT_LOCK: begin
                w_cnt_nx  = '0;
                w_dom_nx  = '0;
                w_done_nx = 1'b0;
                if (w_lock_s) begin
                    w_state_nx = ST_HOLD;
                end else begin
                    w_state_nx = ST_WAIT_LOCK;
                end
            end
            ST_HOLD: begin
                w_dom_nx  = '0;
                w_done_nx = 1'b0;
                if (!w_lock_s) begin
                    w_state_nx = ST_WAIT_LOCK;
                    w_cnt_nx   = '0;
                end else if (r_cnt == HOLD_LAST) begin
                    w_cnt_nx = '0;
                    w_dom_nx = w_dom_shift;
                    if (&w_dom_shift) begin
                        w_state_nx = ST_RUN;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_state_nx = ST_RELEASE;
                    end
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1'b1);
                end
            end
            ST_RELEASE: begin
                if (!w_lock_s) begin
                    w_state_nx = ST_WAIT_LOCK;
                    w_cnt_nx   = '0;
                    w_dom_nx   = '0;
                    w_done_nx  = 1'b0;
                end else if (r_cnt == GAP_LAST) begin
                    w_cnt_nx = '0;
                    w_dom_nx = w_dom_shift;
                    if (&w_dom_shift) begin
                        w_state_nx = ST_RUN;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_state_nx = ST_RELEASE;
                    end
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1'b1);
                end
            end
            ST_RUN: begin
                if (!w_lock_s) begin
                    w_state_nx = ST_WAIT_LOCK;
                    w_dom_nx   = '0;
                    w_done_nx  = 1'b0;
                end else if (sw_reset_req) begin
                    w_state_nx = ST_SWRST;
                    w_dom_nx   = '0;
                    w_done_nx  = 1'b0;
                    w_ack_nx   = 1'b1;
                end else begin
                    w_state_nx = ST_RUN;
                end
            end
            ST_SWRST: begin
                w_dom_nx  = '0;
                w_done_nx = 1'b0;
                w_cnt_nx  = '0;
                if (!w_lock_s) begin
                    w_state_nx = ST_WAIT_LOCK;
                end else if (sw_reset_req) begin
                    w_state_nx = ST_SWRST;
                end else begin
                    w_state_nx = ST_HOLD;
                end
            end
            default: begin
                w_state_nx = ST_ASSERT;
                w_cnt_nx   = '0;
                w_dom_nx   = '0;
                w_done_nx  = 1'b0;
            end
        endcase
    end

    // State, counter and all outputs are flops; resetb clears them asynchronously.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state <= ST_ASSERT;
            r_cnt   <= '0;
            r_dom   <= '0;
            r_done  <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_dom   <= w_dom_nx;
            r_done  <= w_done_nx;
            r_ack   <= w_ack_nx;
        end
    end

    assign domain_resetb = r_dom;
    assign seq_done      = r_done;
    assign sw_reset_ack  = r_ack;
    assign seq_state     = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer: directed scenarios followed by randomized
// lock / software-request / reset activity, checked cycle by cycle against a
// time-based reference model through a scoreboard queue.
module tb_reset_sequencer;

    localparam int SS   = 2;
    localparam int HOLD = 16;
    localparam int GAP  = 4;
    localparam int N    = 3;

    localparam int ST_ASSERT = 0;
    localparam int ST_WAIT   = 1;
    localparam int ST_HOLD   = 2;
    localparam int ST_REL    = 3;
    localparam int ST_RUN    = 4;
    localparam int ST_SW     = 5;

    localparam int PH_PRE  = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_SEQ  = 2;
    localparam int PH_SW   = 3;

    logic         clk = 1'b0;
    logic         resetb;
    logic         pll_lock;
    logic         sw_reset_req;
    logic         sw_reset_ack;
    logic [N-1:0] domain_resetb;
    logic         seq_done;
    logic [2:0]   seq_state;

    typedef struct packed {
        logic [N-1:0] dom;
        logic         done;
        logic         ack;
        logic [2:0]   st;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    int   m_edge  = 0;
    int   m_phase = PH_PRE;
    int   m_t0    = 0;
    bit   m_hist[$];

    always #5 clk = ~clk;

    reset_sequencer #(
        .SYNC_STAGES (SS),
        .HOLD_CYCLES (HOLD),
        .STAGE_GAP   (GAP),
        .NUM_DOMAINS (N),
        .CNT_W       (8)
    ) dut (
        .clk           (clk),
        .resetb        (resetb),
        .pll_lock      (pll_lock),
        .sw_reset_req  (sw_reset_req),
        .sw_reset_ack  (sw_reset_ack),
        .domain_resetb (domain_resetb),
        .seq_done      (seq_done),
        .seq_state     (seq_state)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Number of domains released e edges after hold-phase entry.
    function automatic int bits_at(input int e);
        int b;
        if (e < HOLD) return 0;
        b = (e - HOLD) / GAP + 1;
        return (b > N) ? N : b;
    endfunction

    function automatic exp_t model_out(input int ph, input int e, input bit ack);
        exp_t r;
        int   b;
        r = '0;
        r.ack = ack;
        case (ph)
            PH_PRE:  r.st = 3'(ST_ASSERT);
            PH_WAIT: r.st = 3'(ST_WAIT);
            PH_SW:   r.st = 3'(ST_SW);
            default: begin
                b      = bits_at(e);
                r.dom  = N'((1 << b) - 1);
                r.done = (b == N);
                r.st   = (b == 0) ? 3'(ST_HOLD) : ((b == N) ? 3'(ST_RUN) : 3'(ST_REL));
            end
        endcase
        return r;
    endfunction

    // Reference model: advances once per clk edge, pushes the expected outputs.
    initial begin : model
        bit lock_s;
        bit ack;
        forever begin
            @(posedge clk or negedge resetb);
            if (resetb !== 1'b1) begin
                m_edge  = 0;
                m_phase = PH_PRE;
                m_t0    = 0;
                m_hist.delete();
                sb_q.delete();
                sb_q.push_back('0);
            end else begin
                m_edge++;
                lock_s = (m_hist.size() == SS) ? m_hist[0] : 1'b0;
                m_hist.push_back(pll_lock);
                if (m_hist.size() > SS) void'(m_hist.pop_front());
                ack = 1'b0;
                case (m_phase)
                    PH_PRE: if (m_edge >= SS + 1) m_phase = PH_WAIT;
                    PH_WAIT: if (lock_s) begin
                        m_phase = PH_SEQ;
                        m_t0    = m_edge;
                    end
                    PH_SEQ: if (!lock_s) m_phase = PH_WAIT;
                            else if (sw_reset_req && bits_at(m_edge - 1 - m_t0) == N) begin
                                m_phase = PH_SW;
                                ack     = 1'b1;
                            end
                    default: if (!lock_s) m_phase = PH_WAIT;
                             else if (!sw_reset_req) begin
                                 m_phase = PH_SEQ;
                                 m_t0    = m_edge;
                             end
                endcase
                sb_q.push_back(model_out(m_phase, m_edge - m_t0, ack));
            end
        end
    end

    // Monitor: every falling edge the DUT presents a fresh output set.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_empty actual=0 expected=1 entries");
            end else begin
                e = sb_q.pop_front();
                chk("domain_resetb", domain_resetb, e.dom);
                chk("seq_done", seq_done, e.done);
                chk("sw_reset_ack", sw_reset_ack, e.ack);
                chk("seq_state", seq_state, e.st);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_dom(input logic [N-1:0] v, input int budget, output int at_edge);
        at_edge = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (domain_resetb === v) begin
                at_edge = m_edge;
                break;
            end
        end
    endtask

    task automatic chk_async_zero(input string nm);
        chk({nm, "_dom"}, domain_resetb, 0);
        chk({nm, "_done"}, seq_done, 0);
        chk({nm, "_ack"}, sw_reset_ack, 0);
        chk({nm, "_state"}, seq_state, ST_ASSERT);
    endtask

    initial begin : stimulus
        int e;
        int x;
        int acks;
        int swc;
        int hold_e;

        // 1: power-up with lock already high.
        resetb = 1'b0; pll_lock = 1'b1; sw_reset_req = 1'b0;
        tick(3);
        chk_async_zero("t1_reset");
        resetb = 1'b1;
        wait_dom(3'b001, 40, e); chk("t1_dom001_edge", e, 20);
        wait_dom(3'b011, 10, e); chk("t1_dom011_edge", e, 24);
        wait_dom(3'b111, 10, e); chk("t1_dom111_edge", e, 28);
        chk("t1_seq_done", seq_done, 1);

        // 2: lock rises late, then a one-cycle lock glitch during hold.
        resetb = 1'b0; pll_lock = 1'b0;
        tick(2);
        resetb = 1'b1;
        tick(40);
        chk("t2_wait_lock", seq_state, ST_WAIT);
        pll_lock = 1'b1;
        tick(10);
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        wait_dom(3'b001, 40, e); chk("t2_restart_edge", e, 70);

        // 3: lock loss in RUN, then recovery.
        wait_dom(3'b111, 20, e); chk("t3_reach_run", (e >= 0), 1);
        pll_lock = 1'b0;
        tick(3);
        chk("t3_dom_cleared", domain_resetb, 0);
        chk("t3_done_cleared", seq_done, 0);
        pll_lock = 1'b1;
        x = m_edge;
        wait_dom(3'b111, 50, e);
        chk("t3_resequence_edge", e, x + SS + 1 + HOLD + (N - 1) * GAP);

        // 4: software re-sequence held for 5 cycles, then ignored request in HOLD.
        acks = 0; swc = 0;
        sw_reset_req = 1'b1;
        repeat (5) begin
            tick();
            acks += int'(sw_reset_ack);
            swc  += int'(seq_state == 3'(ST_SW));
        end
        sw_reset_req = 1'b0;
        hold_e = m_edge + 1;
        repeat (3) begin
            tick();
            acks += int'(sw_reset_ack);
            swc  += int'(seq_state == 3'(ST_SW));
        end
        chk("t4_ack_count", acks, 1);
        chk("t4_swrst_cycles", swc, 5);
        chk("t4_in_hold", seq_state, ST_HOLD);
        acks = 0;
        sw_reset_req = 1'b1;
        tick();
        acks += int'(sw_reset_ack);
        sw_reset_req = 1'b0;
        tick();
        acks += int'(sw_reset_ack);
        chk("t4_hold_no_ack", acks, 0);
        wait_dom(3'b001, 30, e); chk("t4_release_edge", e, hold_e + HOLD);

        // 5: asynchronous reset during RELEASE.
        wait_dom(3'b011, 20, e); chk("t5_reach_011", (e >= 0), 1);
        resetb = 1'b0;
        #1;
        chk_async_zero("t5_async");
        tick(2);
        resetb = 1'b1;
        wait_dom(3'b001, 40, e); chk("t5_restart_edge", e, 20);

        // 6: lock loss and software request seen together in RUN.
        wait_dom(3'b111, 20, e); chk("t6_reach_run", (e >= 0), 1);
        pll_lock = 1'b0;
        tick(SS);
        sw_reset_req = 1'b1;
        acks = 0;
        repeat (4) begin
            tick();
            acks += int'(sw_reset_ack);
        end
        chk("t6_no_ack", acks, 0);
        chk("t6_wait_lock", seq_state, ST_WAIT);
        sw_reset_req = 1'b0;
        pll_lock = 1'b1;

        // Randomized activity, checked entirely by the scoreboard.
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (pll_lock) pll_lock = ($urandom_range(99) >= 2);
            else          pll_lock = ($urandom_range(99) >= 40);
            if ($urandom_range(99) < 10) sw_reset_req = ~sw_reset_req;
            if ($urandom_range(999) < 4) begin
                resetb = 1'b0;
                #1;
                chk_async_zero("rnd_async");
                tick($urandom_range(3, 1));
                resetb = 1'b1;
            end
        end

        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Sits directly downstream of the power-on-reset generator. Its resetb input is driven by porb_l, ANDed upstream with the external reset pad.
- Synchronises reset release to the core clock and waits for the PLL lock.
- Releases NUM_DOMAINS core reset domains one at a time, in ascending order, with programmed gaps between them.
- Supports a software-requested re-sequence using a level handshake.

Parameters:
- SYNC_STAGES, 2: flop depth of the reset-release synchroniser and of the pll_lock synchroniser (legal range 2 or more).
- HOLD_CYCLES, 16: number of clk edges with lock continuously stable before domain 0 is released (legal range 1 or more).
- STAGE_GAP, 4: number of clk edges between consecutive domain releases (legal range 1 or more).
- NUM_DOMAINS, 3: number of staged reset outputs (legal range 1 or more).
- CNT_W, 8: counter width. It must hold max(HOLD_CYCLES, STAGE_GAP).

Ports:
- clk, input, 1: core clock.
- resetb, input, 1: asynchronous active-low reset. Assertion is asynchronous; release is synchronised internally.
- pll_lock, input, 1: PLL lock. Asynchronous to clk; synchronised internally.
- sw_reset_req, input, 1: software re-sequence request, level signal synchronous to clk.
- sw_reset_ack, output, 1: one-cycle acknowledge of sw_reset_req.
- domain_resetb, output, NUM_DOMAINS: active-low domain resets. Every bit is a registered output.
- seq_done, output, 1: high while all domains are released.
- seq_state, output, 3: current FSM state, for debug.

Behaviour:
- While resetb is low (asynchronous):
  - domain_resetb = 0, seq_done = 0, sw_reset_ack = 0.
  - seq_state = ASSERT.
  - All counters and synchroniser flops are cleared.
- Reset release:
  - Edges are numbered from 1 starting with the first rising clk edge after resetb rises.
  - The internal synchronised reset rst_n_s goes high at edge SYNC_STAGES.
  - The FSM leaves ASSERT at edge SYNC_STAGES+1.
- pll_lock_s is pll_lock delayed by SYNC_STAGES edges. Its synchroniser resets to 0.
- ASSERT -> WAIT_LOCK when rst_n_s = 1.
- WAIT_LOCK -> HOLD on the first edge where pll_lock_s = 1. The counter clears on entry.
- HOLD:
  - The counter increments each edge.
  - At the HOLD_CYCLES-th edge after entering HOLD, the FSM enters RELEASE and domain_resetb[0] is set in the same edge.
  - If pll_lock_s drops during HOLD: return to WAIT_LOCK and clear the counter.
- RELEASE:
  - domain_resetb[i] is set STAGE_GAP*i edges after domain_resetb[0].
  - Bits are set in ascending order and never skipped.
  - On the edge that sets bit NUM_DOMAINS-1: seq_done = 1 and the FSM enters RUN.
  - With NUM_DOMAINS = 1, the FSM goes from HOLD directly to RUN, setting bit 0 and seq_done together.
- pll_lock_s = 0 during RELEASE or RUN:
  - Next edge: domain_resetb = 0, seq_done = 0, FSM enters WAIT_LOCK.
- RUN with sw_reset_req = 1:
  - Next edge: FSM enters SWRST, domain_resetb = 0, seq_done = 0, sw_reset_ack = 1 for exactly that one cycle.
- SWRST:
  - Stays while sw_reset_req = 1.
  - When sw_reset_req = 0: enters HOLD (the counter clears), then follows the normal sequence.
  - If pll_lock_s = 0 in SWRST: enters WAIT_LOCK.
- sw_reset_req is ignored in every state other than RUN. No ack is issued in those states.
- Simultaneous lock loss and sw_reset_req in RUN: lock loss wins. The FSM enters WAIT_LOCK and no ack is issued.
- If resetb is asserted mid-sequence, every output returns to its reset value immediately (asynchronously).
- seq_state encoding: ASSERT=0, WAIT_LOCK=1, HOLD=2, RELEASE=3, RUN=4, SWRST=5. Codes 6 and 7 are unreachable and recover to ASSERT.
- domain_resetb and seq_done are driven only from flops, with no combinational path from any input.

Decomposition:
- Package reset_seq_pkg holds the state encodings (ASSERT..SWRST) and the 3-bit state width constant.
- One sub-module, reset_sync: a SYNC_STAGES-deep flop chain with asynchronous clear.
  - It is instantiated twice.
  - In the reset-release instance, the D input is tied to 1 and the clear is resetb; the output is rst_n_s.
  - In the lock instance, the D input is pll_lock and the clear is resetb.

Test Plan:
1. Power-up with defaults, pll_lock held high, resetb rises before edge 1 -> expected timing:
   - WAIT_LOCK at edge 3, HOLD at edge 4.
   - domain_resetb = 001 at edge 20, 011 at edge 24, 111 at edge 28.
   - seq_done = 1 at edge 28.
2. pll_lock low at power-up, rising later at edge 40 -> FSM holds in WAIT_LOCK, and domain_resetb[0] rises 2+1+16 = 19 edges after edge 40. Additionally, drop pll_lock for one cycle at HOLD count 10 -> FSM returns to WAIT_LOCK and the full count of 16 restarts.
3. In RUN, drop pll_lock -> domain_resetb = 000 and seq_done = 0 within 3 edges. When lock returns, the full sequence repeats.
4. In RUN, hold sw_reset_req high for 5 cycles -> expected response:
   - One-cycle sw_reset_ack, domain_resetb = 000, state SWRST for 5 cycles.
   - Then HOLD, with domain_resetb[0] rising 16 edges after HOLD entry.
   - A sw_reset_req pulse during HOLD produces no ack.
5. Assert resetb during RELEASE, when domain_resetb = 011 -> all outputs go to 0 asynchronously before the next edge, and the sequence restarts from edge 1 after release.
6. In RUN, drop pll_lock and raise sw_reset_req in the same cycle -> WAIT_LOCK is entered and sw_reset_ack stays 0.
